ring_counter: RTL and testbench

RING_COUNTER -- requirements
Module: ring_counter

---
 rtl/ring_counter_pkg.sv | 21 ++
 rtl/ring_counter_if.sv | 18 +
 rtl/ring_counter_onehot_check.sv | 13 +
 rtl/ring_counter.sv | 107 ++++++++++
 tb/tb_ring_counter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ring_counter_pkg.sv
// ring_counter_pkg -- shared constants and helpers for the ring counter slice.
//   DEFAULT_WIDTH / DEFAULT_INIT : default ring size and one-hot load pattern
//   ring_dir_e                   : rotation direction encoding
//   onehot64()                   : one-hot test, usable in logic and assertions
package ring_counter_pkg;

    localparam int         DEFAULT_WIDTH = 4;
    localparam logic [3:0] DEFAULT_INIT  = 4'b0001;
    localparam int         MAX_WIDTH     = 64;

    typedef enum logic {
        DIR_TOWARD_LSB = 1'b0,
        DIR_TOWARD_MSB = 1'b1
    } ring_dir_e;

    // True when exactly one bit is set; narrower vectors are zero-extended
    function automatic logic onehot64(input logic [63:0] vec);
        return (vec != 64'd0) && ((vec & (vec - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/ring_counter_if.sv
// ring_counter_if -- bundles the ring counter's reset and state outputs.
//   clk   : sole clock (interface port)
//   rst   : synchronous active-high reset
//   count : one-hot ring state
//   master: the counter side (drives count); slave: the consumer side
interface ring_counter_if
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic clk
);
    logic             rst;
    logic [WIDTH-1:0] count;

    modport master (input clk, input rst, output count);
    modport slave  (input clk, input rst, input  count);
endinterface

// File: rtl/ring_counter_onehot_check.sv
// ring_onehot_check -- combinational one-hot detector for the ring state.
//   vec       : vector under test (WIDTH bits)
//   is_onehot : 1 when exactly one bit of vec is set
module ring_onehot_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic             is_onehot
);
    // Clearing the lowest set bit leaves zero only for a single-bit vector
    assign is_onehot = (vec != {WIDTH{1'b0}}) &&
                       ((vec & (vec - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
endmodule

// File: rtl/ring_counter.sv
// ring_counter -- one-hot ring counter with self-correction.
//   clk   : sole clock, rising edge
//   rst   : synchronous active-high reset, loads INIT
//   count : registered ring state, one bit high in every legal state
// Any non-one-hot state (power-up garbage, upset) is replaced by INIT on the
// next non-reset edge instead of being rotated.

// ring_counter_chk -- simulation-only properties for the ring counter.
module ring_counter_chk
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] count,
    input logic [WIDTH-1:0] next
);
    logic seen_reset_r;

    // Remember that the counter has been through at least one reset edge
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_reset_r <= 1'b1;
        end else begin
            seen_reset_r <= seen_reset_r;
        end
    end

    // Every value the counter loads after reset must be one-hot
    a_next_onehot: assert property (@(posedge clk)
        (seen_reset_r === 1'b1) |-> onehot64(64'(next)));

    // The value loaded by a reset edge must be one-hot
    a_reset_onehot: assert property (@(posedge clk)
        rst |=> onehot64(64'(count)));
endmodule

module ring_counter
    import ring_counter_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(1),
    parameter bit               DIR_LEFT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] rot_s;
    logic [WIDTH-1:0] next_s;
    logic             is_onehot_s;

    if ((WIDTH < 2) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
        $error("ring_counter: WIDTH must be in 2..64");
    end
    if (!onehot64(64'(INIT))) begin : g_bad_init
        $error("ring_counter: INIT must have exactly one bit set");
    end

    ring_onehot_check #(
        .WIDTH (WIDTH)
    ) u_onehot (
        .vec       (count_r),
        .is_onehot (is_onehot_s)
    );

    // Next state: rotate a legal state, otherwise fall back to INIT
    always_comb begin
        rot_s  = count_r;
        next_s = INIT;
        if (DIR_LEFT == bit'(DIR_TOWARD_MSB)) begin
            rot_s = {count_r[WIDTH-2:0], count_r[WIDTH-1]};
        end else begin
            rot_s = {count_r[0], count_r[WIDTH-1:1]};
        end
        if (is_onehot_s) begin
            next_s = rot_s;
        end else begin
            next_s = INIT;
        end
    end

    // State register; reset wins over rotation and correction
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= INIT;
        end else begin
            count_r <= next_s;
        end
    end

    assign count = count_r;

`ifndef SYNTHESIS
    ring_counter_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .count (count_r),
        .next  (next_s)
    );
`endif

endmodule

// File: tb/tb_ring_counter.sv
// tb_ring_counter -- self-checking bench for ring_counter: a default 4-bit
// left-rotating instance and an 8-bit right-rotating instance with INIT=8'h80.
module tb_ring_counter;

    logic clk;

    ring_counter_if #(.WIDTH(4)) bus4 (.clk(clk));
    ring_counter_if #(.WIDTH(8)) bus8 (.clk(clk));

    ring_counter u_dut4 (
        .clk   (clk),
        .rst   (bus4.rst),
        .count (bus4.count)
    );

    ring_counter #(
        .WIDTH    (8),
        .INIT     (8'h80),
        .DIR_LEFT (1'b0)
    ) u_dut8 (
        .clk   (clk),
        .rst   (bus8.rst),
        .count (bus8.count)
    );

    // Reference model state (written only by the model process)
    logic [7:0] m4, m8;
    logic       v4, v8;
    int         seen_inj4;

    // Injection requests from the stimulus process
    logic [7:0] inj_val4;
    int         inj_cnt4;

    // Literal expectations indexed by compare cycle
    logic       lit_has4 [0:1023];
    logic [7:0] lit_exp4 [0:1023];
    logic       lit_has8 [0:1023];
    logic [7:0] lit_exp8 [0:1023];

    int cyc;
    int checks;
    int failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ring behaviour: reset -> init, non-one-hot -> init, else move the hot bit
    function automatic logic [7:0] model_step(input logic [7:0] cur, input int w,
                                              input bit left, input logic [7:0] init,
                                              input logic rst);
        int pos;
        if (rst) return init;
        if ($countones(cur) != 1) return init;
        pos = 0;
        for (int i = 0; i < w; i++) if (cur[i]) pos = i;
        pos = left ? (pos + 1) % w : (pos + w - 1) % w;
        return 8'b1 << pos;
    endfunction

    initial begin
        m4 = 8'h00; m8 = 8'h00; v4 = 1'b0; v8 = 1'b0; seen_inj4 = 0;
    end

    always @(posedge clk) begin
        logic [7:0] cur4;
        cur4 = m4;
        if (inj_cnt4 != seen_inj4) begin
            cur4      = inj_val4;
            seen_inj4 = inj_cnt4;
        end
        m4 = model_step(cur4, 4, 1'b1, 8'h01, bus4.rst);
        m8 = model_step(m8, 8, 1'b0, 8'h80, bus8.rst);
        if (bus4.rst) v4 = 1'b1;
        if (bus8.rst) v8 = 1'b1;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Single compare process, sampling on the falling edge
    initial begin
        cyc = 0; checks = 0; failures = 0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (v4) begin
                chk("model4", {4'b0000, bus4.count}, m4);
                chk("onehot4", 8'($countones(bus4.count)), 8'd1);
            end
            if (v8) begin
                chk("model8", bus8.count, m8);
                chk("onehot8", 8'($countones(bus8.count)), 8'd1);
            end
            if (lit_has4[cyc]) chk("lit4", {4'b0000, bus4.count}, lit_exp4[cyc]);
            if (lit_has8[cyc]) chk("lit8", bus8.count, lit_exp8[cyc]);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect4(input logic [7:0] val);
        lit_has4[cyc+1] = 1'b1;
        lit_exp4[cyc+1] = val;
    endtask

    task automatic expect8(input logic [7:0] val);
        lit_has8[cyc+1] = 1'b1;
        lit_exp8[cyc+1] = val;
    endtask

    task automatic inject4(input logic [3:0] val);
        #1;
        force u_dut4.count_r = val;
        inj_val4 = {4'b0000, val};
        inj_cnt4 = inj_cnt4 + 1;
        #1;
        release u_dut4.count_r;
    endtask

    logic [7:0] seq4 [0:8];
    logic [7:0] seq8 [0:8];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            lit_has4[i] = 1'b0; lit_exp4[i] = 8'h00;
            lit_has8[i] = 1'b0; lit_exp8[i] = 8'h00;
        end
        inj_val4 = 8'h00; inj_cnt4 = 0;
        seq4 = '{8'h02, 8'h04, 8'h08, 8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h02};
        seq8 = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80, 8'h40};
        bus4.rst = 1'b1;
        bus8.rst = 1'b1;

        // Two reset edges, then release and walk the ring with literals
        step();
        expect4(8'h01); expect8(8'h80);
        step();
        bus4.rst = 1'b0;
        bus8.rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            expect4(seq4[i]);
            expect8(seq8[i]);
            step();
        end

        // Free run
        for (int i = 0; i < 20; i++) step();

        // Reset while the hot bit sits at 0100
        for (int i = 0; i < 8 && m4 != 8'h04; i++) step();
        bus4.rst = 1'b1;
        expect4(8'h01);
        step();
        bus4.rst = 1'b0;
        expect4(8'h02);
        step();

        // Corrupt the state: two bits set, then none
        inject4(4'b0110);
        expect4(8'h01);
        step();
        inject4(4'b0000);
        expect4(8'h01);
        step();
        expect4(8'h02);
        step();

        // Reset pulses that never span a rising edge
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2 bus4.rst = 1'b1; bus8.rst = 1'b1;
            #2 bus4.rst = 1'b0; bus8.rst = 1'b0;
            step();
        end
        for (int i = 0; i < 6; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
